// File: rtl/axi_lite_register_module_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_if: AXI4-Lite bus bundle with master/slave views.
// Rev 1.0
// ----------------------------------------------------------------------------
interface axi_lite_if #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_register_module.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_register_module: AXI4-Lite register file (18 bias, control, status).
// Rev 1.0
// ----------------------------------------------------------------------------
module axi_lite_register_module #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32
) (
   input  wire                   aclk,
   input  wire                   areset,
   axi_lite_if.slave             s_axil,
   output logic [DATA_WIDTH-1:0] bias_0,
   output logic [DATA_WIDTH-1:0] bias_1,
   output logic [DATA_WIDTH-1:0] bias_2,
   output logic [DATA_WIDTH-1:0] bias_3,
   output logic [DATA_WIDTH-1:0] bias_4,
   output logic [DATA_WIDTH-1:0] bias_5,
   output logic [DATA_WIDTH-1:0] bias_6,
   output logic [DATA_WIDTH-1:0] bias_7,
   output logic [DATA_WIDTH-1:0] bias_8,
   output logic [DATA_WIDTH-1:0] bias_9,
   output logic [DATA_WIDTH-1:0] bias_10,
   output logic [DATA_WIDTH-1:0] bias_11,
   output logic [DATA_WIDTH-1:0] bias_12,
   output logic [DATA_WIDTH-1:0] bias_13,
   output logic [DATA_WIDTH-1:0] bias_14,
   output logic [DATA_WIDTH-1:0] bias_15,
   output logic [DATA_WIDTH-1:0] bias_16,
   output logic [DATA_WIDTH-1:0] bias_17,
   output logic [DATA_WIDTH-1:0] control,
   input  wire  [DATA_WIDTH-1:0] status
);
   localparam int IDX_W    = ADDR_WIDTH - 2;
   localparam int NUM_RW   = 19;
   localparam int NUM_BYTE = DATA_WIDTH / 8;
   localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(19);

   // Entries 0..17 are the biases, entry 18 is control.
   logic [DATA_WIDTH-1:0] reg_file [NUM_RW];
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_bits;

   assign wr_idx = s_axil.awaddr[ADDR_WIDTH-1:2];
   assign rd_idx = s_axil.araddr[ADDR_WIDTH-1:2];
   assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                          s_axil.awaddr[1:0], s_axil.araddr[1:0]};

   assign s_axil.bresp = 2'b00;
   assign s_axil.rresp = 2'b00;

   // Write channel: ready pulse, then byte-wise update on the handshake edge.
   always_ff @(posedge aclk) begin
      if (areset) begin
         s_axil.awready <= 1'b0;
         s_axil.wready  <= 1'b0;
         s_axil.bvalid  <= 1'b0;
         for (int i = 0; i < NUM_RW; i++) begin
            reg_file[i] <= '0;
         end
      end else begin
         if (s_axil.awready) begin
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b0;
            if (s_axil.awvalid && s_axil.wvalid) begin
               s_axil.bvalid <= 1'b1;
               for (int i = 0; i < NUM_RW; i++) begin
                  if (wr_idx == IDX_W'(i)) begin
                     for (int b = 0; b < NUM_BYTE; b++) begin
                        if (s_axil.wstrb[b]) begin
                           reg_file[i][8*b +: 8] <= s_axil.wdata[8*b +: 8];
                        end
                     end
                  end
               end
            end
         end else if (s_axil.awvalid && s_axil.wvalid && !s_axil.bvalid) begin
            s_axil.awready <= 1'b1;
            s_axil.wready  <= 1'b1;
         end
         if (s_axil.bvalid && s_axil.bready) begin
            s_axil.bvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_word = reg_file[i];
         end
      end
      if (rd_idx == STATUS_IDX) begin
         rd_word = status;
      end
   end

   // Read channel: rdata captured on the AR handshake edge, held until accepted.
   always_ff @(posedge aclk) begin
      if (areset) begin
         s_axil.arready <= 1'b0;
         s_axil.rvalid  <= 1'b0;
         s_axil.rdata   <= '0;
      end else begin
         if (s_axil.arready) begin
            s_axil.arready <= 1'b0;
            if (s_axil.arvalid) begin
               s_axil.rvalid <= 1'b1;
               s_axil.rdata  <= rd_word;
            end
         end else if (s_axil.arvalid && !s_axil.rvalid) begin
            s_axil.arready <= 1'b1;
         end
         if (s_axil.rvalid && s_axil.rready) begin
            s_axil.rvalid <= 1'b0;
         end
      end
   end

   assign bias_0  = reg_file[0];
   assign bias_1  = reg_file[1];
   assign bias_2  = reg_file[2];
   assign bias_3  = reg_file[3];
   assign bias_4  = reg_file[4];
   assign bias_5  = reg_file[5];
   assign bias_6  = reg_file[6];
   assign bias_7  = reg_file[7];
   assign bias_8  = reg_file[8];
   assign bias_9  = reg_file[9];
   assign bias_10 = reg_file[10];
   assign bias_11 = reg_file[11];
   assign bias_12 = reg_file[12];
   assign bias_13 = reg_file[13];
   assign bias_14 = reg_file[14];
   assign bias_15 = reg_file[15];
   assign bias_16 = reg_file[16];
   assign bias_17 = reg_file[17];
   assign control = reg_file[18];
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_register_module.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axi_lite_register_module: directed self-checking bench for the register file.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_axi_lite_register_module;
   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] status;
   logic [31:0] control;
   wire  [31:0] bias_w [18];
   logic [31:0] exp_bias [18];
   logic [31:0] exp_control;
   logic [31:0] rd;
   int          n_cmp = 0;
   int          n_err = 0;

   axi_lite_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

   axi_lite_register_module #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .areset(areset), .s_axil(bus),
      .bias_0(bias_w[0]),   .bias_1(bias_w[1]),   .bias_2(bias_w[2]),
      .bias_3(bias_w[3]),   .bias_4(bias_w[4]),   .bias_5(bias_w[5]),
      .bias_6(bias_w[6]),   .bias_7(bias_w[7]),   .bias_8(bias_w[8]),
      .bias_9(bias_w[9]),   .bias_10(bias_w[10]), .bias_11(bias_w[11]),
      .bias_12(bias_w[12]), .bias_13(bias_w[13]), .bias_14(bias_w[14]),
      .bias_15(bias_w[15]), .bias_16(bias_w[16]), .bias_17(bias_w[17]),
      .control(control), .status(status)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int i = 0; i < 18; i++) begin
         check($sformatf("%s_bias%0d", tag, i), bias_w[i], exp_bias[i]);
      end
      check({tag, "_control"}, control, exp_control);
   endtask

   task automatic wait_aw();
      int cnt = 0;
      while (!bus.awready && cnt < 20) begin
         @(negedge aclk);
         cnt++;
      end
      check("aw_timeout", 32'(cnt < 20), 32'd1);
   endtask

   task automatic wait_ar();
      int cnt = 0;
      while (!bus.arready && cnt < 20) begin
         @(negedge aclk);
         cnt++;
      end
      check("ar_timeout", 32'(cnt < 20), 32'd1);
   endtask

   task automatic finish_write();
      int cnt = 0;
      @(posedge aclk);
      #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      @(negedge aclk);
      while (!bus.bvalid && cnt < 20) begin
         @(negedge aclk);
         cnt++;
      end
      check("b_timeout", 32'(cnt < 20), 32'd1);
      check("bresp", 32'(bus.bresp), 32'd0);
      bus.bready = 1'b1;
      @(posedge aclk);
      #1;
      bus.bready = 1'b0;
   endtask

   task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge aclk);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      wait_aw();
      finish_write();
   endtask

   task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
      int cnt = 0;
      @(negedge aclk);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      wait_ar();
      @(posedge aclk);
      #1;
      bus.arvalid = 1'b0;
      @(negedge aclk);
      while (!bus.rvalid && cnt < 20) begin
         @(negedge aclk);
         cnt++;
      end
      check("r_timeout", 32'(cnt < 20), 32'd1);
      check("rresp", 32'(bus.rresp), 32'd0);
      d = bus.rdata;
      bus.rready = 1'b1;
      @(posedge aclk);
      #1;
      bus.rready = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      status = 32'h0;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      for (int i = 0; i < 18; i++) exp_bias[i] = 32'h0;
      exp_control = 32'h0;
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;

      // Reset state
      @(negedge aclk);
      check("rst_awready", 32'(bus.awready), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_rdata", bus.rdata, 32'h0);
      check_outputs("rst");
      for (int i = 0; i < 19; i++) begin
         axi_read(7'(4 * i), rd);
         check($sformatf("rst_read%0d", i), rd, 32'h0);
      end

      // Bias registers one by one
      for (int i = 0; i < 18; i++) begin
         axi_write(7'(4 * i), 32'h678 + i, 4'hF);
         exp_bias[i] = 32'h678 + i;
         check_outputs($sformatf("wr%0d", i));
         axi_read(7'(4 * i), rd);
         check($sformatf("rd_bias%0d", i), rd, 32'h678 + i);
      end

      // Control
      axi_write(7'h48, 32'h678, 4'hF);
      exp_control = 32'h678;
      axi_read(7'h48, rd);
      check("rd_control", rd, 32'h678);
      check_outputs("ctrl");

      // Status is read-only
      status = 32'hABCDEF01;
      axi_read(7'h4C, rd);
      check("rd_status", rd, 32'hABCDEF01);
      axi_write(7'h4C, 32'h12345678, 4'hF);
      axi_read(7'h4C, rd);
      check("rd_status_after_wr", rd, 32'hABCDEF01);
      check_outputs("status_wr");

      // Byte strobes
      axi_write(7'h0C, 32'hFFFFFFFF, 4'hF);
      axi_write(7'h0C, 32'h000000AA, 4'h1);
      exp_bias[3] = 32'hFFFFFFAA;
      check("strb_bias3", bias_w[3], 32'hFFFFFFAA);
      axi_read(7'h7C, rd);
      check("rd_unmapped", rd, 32'h0);

      // Write backpressure with a second write queued behind it
      @(negedge aclk);
      bus.awaddr = 7'h14; bus.wdata = 32'h11112222; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      wait_aw();
      @(posedge aclk);
      #1;
      bus.awaddr = 7'h18; bus.wdata = 32'h33334444;
      exp_bias[5] = 32'h11112222;
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         check("bp_bvalid", 32'(bus.bvalid), 32'd1);
         check("bp_bresp", 32'(bus.bresp), 32'd0);
         check("bp_awready", 32'(bus.awready), 32'd0);
         check("bp_wready", 32'(bus.wready), 32'd0);
      end
      check("bp_bias5", bias_w[5], 32'h11112222);
      check("bp_bias6_old", bias_w[6], exp_bias[6]);
      bus.bready = 1'b1;
      @(posedge aclk);
      #1;
      bus.bready = 1'b0;
      @(negedge aclk);
      wait_aw();
      finish_write();
      exp_bias[6] = 32'h33334444;
      check("bp_bias6", bias_w[6], 32'h33334444);

      // Read backpressure with a second read queued behind it
      @(negedge aclk);
      bus.araddr = 7'h14; bus.arvalid = 1'b1;
      wait_ar();
      @(posedge aclk);
      #1;
      bus.araddr = 7'h18;
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         check("bp_rvalid", 32'(bus.rvalid), 32'd1);
         check("bp_rdata", bus.rdata, 32'h11112222);
         check("bp_arready", 32'(bus.arready), 32'd0);
      end
      bus.rready = 1'b1;
      @(posedge aclk);
      #1;
      bus.rready = 1'b0;
      @(negedge aclk);
      wait_ar();
      @(posedge aclk);
      #1;
      bus.arvalid = 1'b0;
      @(negedge aclk);
      check("bp_rvalid2", 32'(bus.rvalid), 32'd1);
      check("bp_rdata2", bus.rdata, 32'h33334444);
      bus.rready = 1'b1;
      @(posedge aclk);
      #1;
      bus.rready = 1'b0;
      @(negedge aclk);
      check("bp_rvalid_clr", 32'(bus.rvalid), 32'd0);
      check_outputs("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
